// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit. Takes the EX/MEM entry, runs the
// data-memory request/response transaction and then presents aligned and
// extended load data on the m_* outputs into the MEM/WB register. stall
// freezes IF..EX/MEM while a transaction is outstanding.
// Optional feature macro: LSU_TIMEOUT_EN adds a grant/response watchdog
// (TIMEOUT_CYCLES) and the bus_err output.
//
// Handshake: the request phase is a valid/ready pair. mem_req is valid and
// mem_gnt is ready. The request is accepted on a clock edge where both are
// high. Once mem_req is raised, mem_we/mem_addr/mem_be/mem_wdata stay stable
// until that edge. The response phase has one valid signal, mem_rvalid,
// with no back-pressure. It is only sampled in WAIT, which starts the cycle
// after the grant.
module mem_stage_lsu #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              x_valid,
    input  logic              x_MemRead,
    input  logic              x_MemWrite,
    input  logic [2:0]        x_funct3,
    input  logic [31:0]       x_alu_result,
    input  logic [31:0]       x_store_data,
    input  logic [4:0]        x_rd,
    input  logic              x_RegWrite,
    input  logic              x_MemToReg,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              stall,
    output logic              misalign,
    output logic [31:0]       m_read_data,
    output logic [31:0]       m_reg_data,
    output logic [4:0]        m_rd,
    output logic              m_RegWrite,
    output logic              m_MemToReg,
    output logic [1:0]        dbg_state
`ifdef LSU_TIMEOUT_EN
    ,
    output logic              bus_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;

    // Latched EX/MEM entry, valid from REQ through DONE
    logic        rd_q;
    logic        wr_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] sdata_q;
    logic [4:0]  dst_q;
    logic        regw_q;
    logic        m2r_q;
    logic [31:0] rdata_q;

    logic        in_idle;
    logic        x_mem_op;
    logic        x_aligned;
    logic        start;
    logic        mis_c;
    logic        timeout_hit;
    logic        timed_out;

    logic [2:0]  cur_f3;
    logic [31:0] cur_addr;
    logic [31:0] cur_sdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;

    assign in_idle   = (state_q == S_IDLE);
    assign x_mem_op  = x_valid & (x_MemRead | x_MemWrite);
    assign start     = ~rst & in_idle & x_mem_op & x_aligned;
    assign mis_c     = ~rst & in_idle & x_mem_op & ~x_aligned;
    assign dbg_state = state_q;

    // Alignment check of the incoming access: bytes always, halves on even, words on 4
    always_comb begin
        x_aligned = 1'b1;
        case (x_funct3[1:0])
            2'b00:   x_aligned = 1'b1;
            2'b01:   x_aligned = ~x_alu_result[0];
            default: x_aligned = (x_alu_result[1:0] == 2'b00);
        endcase
    end

    // Bus fields come straight from EX/MEM in IDLE and from the latches afterwards
    assign cur_f3    = in_idle ? x_funct3 : f3_q;
    assign cur_addr  = in_idle ? x_alu_result : addr_q;
    assign cur_sdata = in_idle ? x_store_data : sdata_q;
    assign mem_addr  = {cur_addr[ADDR_W-1:2], 2'b00};

    // Byte-lane enables and replicated store data for the current access size
    always_comb begin
        mem_be    = 4'b1111;
        mem_wdata = cur_sdata;
        case (cur_f3[1:0])
            2'b00: begin
                mem_be    = 4'b0001 << cur_addr[1:0];
                mem_wdata = {4{cur_sdata[7:0]}};
            end
            2'b01: begin
                mem_be    = cur_addr[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{cur_sdata[15:0]}};
            end
            default: begin
                mem_be    = 4'b1111;
                mem_wdata = cur_sdata;
            end
        endcase
    end

    // Select the addressed lane of the captured word and extend it
    always_comb begin
        ld_byte = rdata_q[7:0];
        case (addr_q[1:0])
            2'd0: ld_byte = rdata_q[7:0];
            2'd1: ld_byte = rdata_q[15:8];
            2'd2: ld_byte = rdata_q[23:16];
            2'd3: ld_byte = rdata_q[31:24];
            default: ld_byte = rdata_q[7:0];
        endcase
        ld_half  = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        load_val = rdata_q;
        case (f3_q)
            3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_val = {24'd0, ld_byte};
            3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_val = {16'd0, ld_half};
            default: load_val = rdata_q;
        endcase
    end

    // State register; reset aborts any transaction back to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = mem_gnt ? S_WAIT : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    state_d = S_WAIT;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                if (mem_rvalid || timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: passthrough in IDLE, latched entry while the access is in flight
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        stall       = 1'b0;
        misalign    = 1'b0;
        m_read_data = 32'd0;
        m_reg_data  = addr_q;
        m_rd        = dst_q;
        m_RegWrite  = 1'b0;
        m_MemToReg  = m2r_q;
        case (state_q)
            S_IDLE: begin
                m_reg_data = x_alu_result;
                m_rd       = x_rd;
                m_MemToReg = x_MemToReg;
                if (start) begin
                    mem_req = 1'b1;
                    mem_we  = x_MemWrite;
                    stall   = 1'b1;
                end else if (mis_c) begin
                    misalign = 1'b1;
                end else begin
                    m_RegWrite = ~rst & x_valid & x_RegWrite;
                end
            end
            S_REQ: begin
                mem_req = 1'b1;
                mem_we  = wr_q;
                stall   = 1'b1;
            end
            S_WAIT: begin
                stall = 1'b1;
            end
            S_DONE: begin
                m_read_data = timed_out ? 32'hDEAD_BEEF : load_val;
                m_RegWrite  = regw_q & ~timed_out;
            end
            default: ;
        endcase
    end

    // Capture the EX/MEM entry at request time and the read word on the load response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            sdata_q <= 32'd0;
            dst_q   <= 5'd0;
            regw_q  <= 1'b0;
            m2r_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else if (start) begin
            rd_q    <= x_MemRead;
            wr_q    <= x_MemWrite;
            f3_q    <= x_funct3;
            addr_q  <= x_alu_result;
            sdata_q <= x_store_data;
            dst_q   <= x_rd;
            regw_q  <= x_RegWrite;
            m2r_q   <= x_MemToReg;
            rdata_q <= 32'd0;
        end else if (state_q == S_WAIT && mem_rvalid && rd_q) begin
            rdata_q <= mem_rdata;
        end
    end

`ifdef LSU_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        to_q, to_d;

    assign timeout_hit = (cnt_q == 32'(TIMEOUT_CYCLES - 1));
    assign timed_out   = to_q;
    assign bus_err     = (state_q == S_DONE) & to_q;

    // Watchdog: counts cycles spent in REQ/WAIT, cleared while IDLE
    always_comb begin
        cnt_d = 32'd0;
        to_d  = 1'b0;
        case (state_q)
            S_REQ: begin
                cnt_d = cnt_q + 32'd1;
                to_d  = ~mem_gnt & timeout_hit;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 32'd1;
                to_d  = ~mem_rvalid & timeout_hit;
            end
            default: ;
        endcase
    end

    // Watchdog counter and timeout flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 32'd0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end
`else
    logic [31:0] unused_timeout;

    assign timeout_hit    = 1'b0;
    assign timed_out      = 1'b0;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed self-checking bench for mem_stage_lsu.
// Inputs are driven 1 ns after the rising edge and outputs are checked 1 ns later.
module tb_mem_stage_lsu;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;
`ifdef LSU_TIMEOUT_EN
    localparam int TO_CYC = 4;
`else
    localparam int TO_CYC = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        x_valid, x_MemRead, x_MemWrite, x_RegWrite, x_MemToReg;
    logic [2:0]  x_funct3;
    logic [31:0] x_alu_result, x_store_data;
    logic [4:0]  x_rd;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;
    logic        stall, misalign;
    logic [31:0] m_read_data, m_reg_data;
    logic [4:0]  m_rd;
    logic        m_RegWrite, m_MemToReg;
    logic [1:0]  dbg_state;
`ifdef LSU_TIMEOUT_EN
    logic        bus_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_lsu #(.ADDR_W(32), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .x_valid(x_valid), .x_MemRead(x_MemRead), .x_MemWrite(x_MemWrite),
        .x_funct3(x_funct3), .x_alu_result(x_alu_result), .x_store_data(x_store_data),
        .x_rd(x_rd), .x_RegWrite(x_RegWrite), .x_MemToReg(x_MemToReg),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall(stall), .misalign(misalign), .m_read_data(m_read_data), .m_reg_data(m_reg_data),
        .m_rd(m_rd), .m_RegWrite(m_RegWrite), .m_MemToReg(m_MemToReg), .dbg_state(dbg_state)
`ifdef LSU_TIMEOUT_EN
        , .bus_err(bus_err)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        x_valid = 1'b0; x_MemRead = 1'b0; x_MemWrite = 1'b0; x_funct3 = 3'd0;
        x_alu_result = 32'd0; x_store_data = 32'd0; x_rd = 5'd0;
        x_RegWrite = 1'b0; x_MemToReg = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    endtask

    task automatic drive_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
        x_valid = 1'b1; x_MemRead = 1'b1; x_MemWrite = 1'b0; x_funct3 = f3;
        x_alu_result = addr; x_rd = rd; x_RegWrite = 1'b1; x_MemToReg = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        drive_load(3'b010, 32'h40, 5'd3);
        settle();
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b exp 0", mem_req); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b exp 0", stall); end
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b exp 0", misalign); end
        n_checks++; if (m_RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %b exp 0", m_RegWrite); end
        n_checks++; if (m_read_data !== 32'd0) begin n_fail++; $display("FAIL reset_read_data: got %h exp 0", m_read_data); end
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, ST_IDLE); end
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alu_passthrough();
        x_valid = 1'b1; x_RegWrite = 1'b1; x_alu_result = 32'h1234; x_rd = 5'd5; x_MemToReg = 1'b0;
        settle();
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b exp 0", stall); end
        n_checks++; if (m_reg_data !== 32'h1234) begin n_fail++; $display("FAIL alu_reg_data: got %h exp 00001234", m_reg_data); end
        n_checks++; if (m_rd !== 5'd5) begin n_fail++; $display("FAIL alu_rd: got %0d exp 5", m_rd); end
        n_checks++; if (m_RegWrite !== 1'b1) begin n_fail++; $display("FAIL alu_regwrite: got %b exp 1", m_RegWrite); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL alu_mem_req: got %b exp 0", mem_req); end
        x_valid = 1'b0;
        settle();
        n_checks++; if (m_RegWrite !== 1'b0) begin n_fail++; $display("FAIL alu_bubble_regwrite: got %b exp 0", m_RegWrite); end
        tick();
        clear_inputs();
    endtask

    task automatic test_lb();
        drive_load(3'b000, 32'h103, 5'd9);
        mem_gnt = 1'b1;
        settle();
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL lb_req: got %b exp 1", mem_req); end
        n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL lb_addr: got %h exp 00000100", mem_addr); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL lb_we: got %b exp 0", mem_we); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lb_stall_c0: got %b exp 1", stall); end
        n_checks++; if (m_RegWrite !== 1'b0) begin n_fail++; $display("FAIL lb_regwrite_c0: got %b exp 0", m_RegWrite); end
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0000;
        settle();
        n_checks++; if (dbg_state !== ST_WAIT) begin n_fail++; $display("FAIL lb_state_wait: got %0d exp %0d", dbg_state, ST_WAIT); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lb_stall_c1: got %b exp 1", stall); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL lb_req_wait: got %b exp 0", mem_req); end
        tick();
        mem_rvalid = 1'b0; x_valid = 1'b0;
        settle();
        n_checks++; if (dbg_state !== ST_DONE) begin n_fail++; $display("FAIL lb_state_done: got %0d exp %0d", dbg_state, ST_DONE); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lb_stall_done: got %b exp 0", stall); end
        n_checks++; if (m_read_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_read_data: got %h exp ffffff80", m_read_data); end
        n_checks++; if (m_RegWrite !== 1'b1) begin n_fail++; $display("FAIL lb_regwrite_done: got %b exp 1", m_RegWrite); end
        n_checks++; if (m_rd !== 5'd9) begin n_fail++; $display("FAIL lb_rd: got %0d exp 9", m_rd); end
        tick();
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL lb_state_idle: got %0d exp %0d", dbg_state, ST_IDLE); end
        clear_inputs();
    endtask

    task automatic test_lhu_delayed_gnt();
        drive_load(3'b101, 32'h202, 5'd7);
        for (int i = 0; i < 4; i++) begin
            mem_gnt = (i == 3);
            settle();
            n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL lhu_req_c%0d: got %b exp 1", i, mem_req); end
            n_checks++; if (mem_addr !== 32'h200) begin n_fail++; $display("FAIL lhu_addr_c%0d: got %h exp 00000200", i, mem_addr); end
            n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lhu_stall_c%0d: got %b exp 1", i, stall); end
            n_checks++; if (dbg_state !== ((i == 0) ? ST_IDLE : ST_REQ)) begin n_fail++; $display("FAIL lhu_state_c%0d: got %0d", i, dbg_state); end
            tick();
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h8001_7FFF;
        settle();
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL lhu_req_wait: got %b exp 0", mem_req); end
        tick();
        mem_rvalid = 1'b0; x_valid = 1'b0;
        settle();
        n_checks++; if (m_read_data !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu_read_data: got %h exp 00008001", m_read_data); end
        n_checks++; if (m_RegWrite !== 1'b1) begin n_fail++; $display("FAIL lhu_regwrite: got %b exp 1", m_RegWrite); end
        tick();
        clear_inputs();
    endtask

    task automatic test_sh();
        x_valid = 1'b1; x_MemWrite = 1'b1; x_funct3 = 3'b001; x_alu_result = 32'h006;
        x_store_data = 32'hAAAA_BEEF; x_RegWrite = 1'b0;
        mem_gnt = 1'b1;
        settle();
        n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL sh_we: got %b exp 1", mem_we); end
        n_checks++; if (mem_be !== 4'b1100) begin n_fail++; $display("FAIL sh_be: got %b exp 1100", mem_be); end
        n_checks++; if (mem_wdata !== 32'hBEEF_BEEF) begin n_fail++; $display("FAIL sh_wdata: got %h exp beefbeef", mem_wdata); end
        n_checks++; if (mem_addr !== 32'h004) begin n_fail++; $display("FAIL sh_addr: got %h exp 00000004", mem_addr); end
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_rvalid = 1'b0; x_valid = 1'b0;
        settle();
        n_checks++; if (dbg_state !== ST_DONE) begin n_fail++; $display("FAIL sh_state_done: got %0d exp %0d", dbg_state, ST_DONE); end
        n_checks++; if (m_RegWrite !== 1'b0) begin n_fail++; $display("FAIL sh_regwrite: got %b exp 0", m_RegWrite); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sh_stall_done: got %b exp 0", stall); end
        tick();
        clear_inputs();
    endtask

    task automatic test_store_lanes();
        logic [2:0]  f3_t [4];
        logic [31:0] ad_t [4];
        logic [31:0] sd_t [4];
        logic [3:0]  be_t [4];
        logic [31:0] wd_t [4];
        f3_t[0] = 3'b000; ad_t[0] = 32'h11; sd_t[0] = 32'h1234_56A5; be_t[0] = 4'b0010; wd_t[0] = 32'hA5A5_A5A5;
        f3_t[1] = 3'b000; ad_t[1] = 32'h13; sd_t[1] = 32'h1234_563C; be_t[1] = 4'b1000; wd_t[1] = 32'h3C3C_3C3C;
        f3_t[2] = 3'b001; ad_t[2] = 32'h20; sd_t[2] = 32'h1234_5678; be_t[2] = 4'b0011; wd_t[2] = 32'h5678_5678;
        f3_t[3] = 3'b010; ad_t[3] = 32'h40; sd_t[3] = 32'h1234_5678; be_t[3] = 4'b1111; wd_t[3] = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            x_valid = 1'b1; x_MemWrite = 1'b1; x_MemRead = 1'b0; x_funct3 = f3_t[i];
            x_alu_result = ad_t[i]; x_store_data = sd_t[i]; x_RegWrite = 1'b0;
            mem_gnt = 1'b1;
            settle();
            n_checks++; if (mem_be !== be_t[i]) begin n_fail++; $display("FAIL store%0d_be: got %b exp %b", i, mem_be, be_t[i]); end
            n_checks++; if (mem_wdata !== wd_t[i]) begin n_fail++; $display("FAIL store%0d_wdata: got %h exp %h", i, mem_wdata, wd_t[i]); end
            tick();
            mem_gnt = 1'b0; mem_rvalid = 1'b1;
            tick();
            mem_rvalid = 1'b0; x_valid = 1'b0;
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_load_extract();
        logic [2:0]  f3_t [8];
        logic [31:0] ad_t [8];
        logic [31:0] rd_t [8];
        logic [31:0] ex_t [8];
        logic [4:0]  exp_rd;
        f3_t[0] = 3'b000; ad_t[0] = 32'h0; rd_t[0] = 32'h1234_56F0; ex_t[0] = 32'hFFFF_FFF0;
        f3_t[1] = 3'b100; ad_t[1] = 32'h1; rd_t[1] = 32'h1234_56F0; ex_t[1] = 32'h0000_0056;
        f3_t[2] = 3'b100; ad_t[2] = 32'h3; rd_t[2] = 32'h8A00_0000; ex_t[2] = 32'h0000_008A;
        f3_t[3] = 3'b001; ad_t[3] = 32'h2; rd_t[3] = 32'h8001_7FFF; ex_t[3] = 32'hFFFF_8001;
        f3_t[4] = 3'b001; ad_t[4] = 32'h0; rd_t[4] = 32'h8001_7FFF; ex_t[4] = 32'h0000_7FFF;
        f3_t[5] = 3'b101; ad_t[5] = 32'h0; rd_t[5] = 32'h0000_F00D; ex_t[5] = 32'h0000_F00D;
        f3_t[6] = 3'b010; ad_t[6] = 32'h4; rd_t[6] = 32'hCAFE_F00D; ex_t[6] = 32'hCAFE_F00D;
        f3_t[7] = 3'b110; ad_t[7] = 32'h8; rd_t[7] = 32'h1357_9BDF; ex_t[7] = 32'h1357_9BDF;
        for (int i = 0; i < 8; i++) begin
            exp_rd = 5'(i + 1);
            drive_load(f3_t[i], ad_t[i], exp_rd);
            mem_gnt = 1'b1;
            tick();
            mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd_t[i];
            tick();
            mem_rvalid = 1'b0; mem_rdata = 32'h0; x_valid = 1'b0; x_rd = 5'd0; x_MemToReg = 1'b0;
            settle();
            n_checks++; if (m_read_data !== ex_t[i]) begin n_fail++; $display("FAIL load%0d_data: got %h exp %h", i, m_read_data, ex_t[i]); end
            n_checks++; if (m_rd !== exp_rd) begin n_fail++; $display("FAIL load%0d_rd: got %0d exp %0d", i, m_rd, exp_rd); end
            n_checks++; if (m_MemToReg !== 1'b1) begin n_fail++; $display("FAIL load%0d_memtoreg: got %b exp 1", i, m_MemToReg); end
            n_checks++; if (m_reg_data !== ad_t[i]) begin n_fail++; $display("FAIL load%0d_reg_data: got %h exp %h", i, m_reg_data, ad_t[i]); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_misalign();
        logic [2:0]  f3_t [3];
        logic [31:0] ad_t [3];
        logic        wr_t [3];
        f3_t[0] = 3'b010; ad_t[0] = 32'h001; wr_t[0] = 1'b0;
        f3_t[1] = 3'b001; ad_t[1] = 32'h003; wr_t[1] = 1'b0;
        f3_t[2] = 3'b010; ad_t[2] = 32'h002; wr_t[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x_valid = 1'b1; x_MemRead = ~wr_t[i]; x_MemWrite = wr_t[i]; x_funct3 = f3_t[i];
            x_alu_result = ad_t[i]; x_RegWrite = ~wr_t[i]; x_rd = 5'd4;
            mem_gnt = 1'b1;
            settle();
            n_checks++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL mis%0d_pulse: got %b exp 1", i, misalign); end
            n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL mis%0d_req: got %b exp 0", i, mem_req); end
            n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mis%0d_stall: got %b exp 0", i, stall); end
            n_checks++; if (m_RegWrite !== 1'b0) begin n_fail++; $display("FAIL mis%0d_regwrite: got %b exp 0", i, m_RegWrite); end
            tick();
            x_valid = 1'b0;
            settle();
            n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL mis%0d_clear: got %b exp 0", i, misalign); end
            n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL mis%0d_state: got %0d exp %0d", i, dbg_state, ST_IDLE); end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        drive_load(3'b010, 32'h30, 5'd6);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        settle();
        n_checks++; if (dbg_state !== ST_WAIT) begin n_fail++; $display("FAIL rstmid_pre_state: got %0d exp %0d", dbg_state, ST_WAIT); end
        rst = 1'b1; x_valid = 1'b0;
        settle();
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rstmid_state: got %0d exp %0d", dbg_state, ST_IDLE); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req: got %b exp 0", mem_req); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b exp 0", stall); end
        tick();
        rst = 1'b0;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        settle();
        n_checks++; if (m_RegWrite !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_regwrite: got %b exp 0", m_RegWrite); end
        n_checks++; if (m_read_data !== 32'd0) begin n_fail++; $display("FAIL rstmid_late_data: got %h exp 0", m_read_data); end
        tick();
        mem_rvalid = 1'b0;
        settle();
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rstmid_after_state: got %0d exp %0d", dbg_state, ST_IDLE); end
        n_checks++; if (m_RegWrite !== 1'b0) begin n_fail++; $display("FAIL rstmid_after_regwrite: got %b exp 0", m_RegWrite); end
        clear_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        drive_load(3'b010, 32'h50, 5'd10);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        mem_rvalid = 1'b0;
        drive_load(3'b010, 32'h54, 5'd11);
        mem_gnt = 1'b1;
        settle();
        n_checks++; if (m_read_data !== 32'h1111_1111) begin n_fail++; $display("FAIL b2b_first_data: got %h exp 11111111", m_read_data); end
        n_checks++; if (m_rd !== 5'd10) begin n_fail++; $display("FAIL b2b_first_rd: got %0d exp 10", m_rd); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_done_req: got %b exp 0", mem_req); end
        tick();
        settle();
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL b2b_second_req: got %b exp 1", mem_req); end
        n_checks++; if (mem_addr !== 32'h54) begin n_fail++; $display("FAIL b2b_second_addr: got %h exp 00000054", mem_addr); end
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
        tick();
        mem_rvalid = 1'b0; x_valid = 1'b0;
        settle();
        n_checks++; if (m_read_data !== 32'h2222_2222) begin n_fail++; $display("FAIL b2b_second_data: got %h exp 22222222", m_read_data); end
        n_checks++; if (m_rd !== 5'd11) begin n_fail++; $display("FAIL b2b_second_rd: got %0d exp 11", m_rd); end
        tick();
        clear_inputs();
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        drive_load(3'b010, 32'h60, 5'd12);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        for (int i = 0; i < TO_CYC; i++) begin
            settle();
            n_checks++; if (dbg_state !== ST_WAIT) begin n_fail++; $display("FAIL to_wait_c%0d: got %0d exp %0d", i, dbg_state, ST_WAIT); end
            tick();
        end
        x_valid = 1'b0;
        settle();
        n_checks++; if (dbg_state !== ST_DONE) begin n_fail++; $display("FAIL to_state: got %0d exp %0d", dbg_state, ST_DONE); end
        n_checks++; if (m_read_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL to_data: got %h exp deadbeef", m_read_data); end
        n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL to_bus_err: got %b exp 1", bus_err); end
        n_checks++; if (m_RegWrite !== 1'b0) begin n_fail++; $display("FAIL to_regwrite: got %b exp 0", m_RegWrite); end
        tick();
        n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL to_bus_err_clear: got %b exp 0", bus_err); end
        clear_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_alu_passthrough();
        test_lb();
        test_lhu_delayed_gnt();
        test_sh();
        test_store_lanes();
        test_load_extract();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Load/store unit for the MEM stage. It is the producer side of the MEM/WB interface: it takes the EX/MEM pipeline contents and runs the data-memory transaction with a request/response handshake. It aligns and extends load data and drives the m_* signals into the MEM/WB register. While a memory transaction is outstanding it asserts stall to freeze the upstream pipeline.

Parameters:
ADDR_W, 32, data-memory byte-address width
TIMEOUT_CYCLES, 255, response-wait limit; used only when the optional feature is compiled in

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-high
x_valid  in  1  EX/MEM entry holds a real instruction
x_MemRead  in  1  load
x_MemWrite  in  1  store
x_funct3  in  3  access size/sign (RV32 encoding)
x_alu_result  in  32  effective address / ALU result
x_store_data  in  32  rs2 data for stores
x_rd  in  5  destination register
x_RegWrite  in  1  register write enable
x_MemToReg  in  1  writeback source select
mem_req  out  1  bus request valid
mem_gnt  in  1  bus accepts request this cycle
mem_we  out  1  1 = store
mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
mem_be  out  4  byte enables
mem_wdata  out  32  lane-aligned store data
mem_rvalid  in  1  response valid (load data or store ack)
mem_rdata  in  32  raw word read data
stall  out  1  freeze IF..EX/MEM this cycle
misalign  out  1  one-cycle pulse: misaligned access dropped
m_read_data  out  32  extended load data
m_reg_data  out  32  ALU result passthrough
m_rd  out  5  destination register
m_RegWrite  out  1  write enable to MEM/WB
m_MemToReg  out  1  writeback select

Behaviour:
- States: IDLE, REQ, WAIT, DONE.
- Reset (async, rst=1): state=IDLE, internal registers 0. Outputs: mem_req=0, stall=0, misalign=0, m_RegWrite=0, m_read_data=0.
- IDLE, no memory op (x_valid=0, or MemRead=MemWrite=0):
  - combinational passthrough, stall=0, m_read_data=0.
  - m_RegWrite=x_valid&x_RegWrite; m_rd, m_reg_data and m_MemToReg taken directly from the x_* inputs.
- IDLE, aligned memory op:
  - latch all x_* inputs; stall=1, m_RegWrite=0.
  - drive mem_req=1 the same cycle. mem_gnt=1 -> WAIT; else -> REQ.
- REQ: hold mem_req=1 and all mem_* stable until mem_gnt=1, then -> WAIT. stall=1.
- WAIT: mem_req=0, stall=1. On mem_rvalid capture mem_rdata -> DONE. A mem_rvalid in the same cycle as the grant is not accepted; the earliest response is the next cycle.
- DONE: stall=0. m_* come from the latches; m_read_data from the captured word; m_RegWrite=latched RegWrite. Next state is IDLE.
  - Minimum memory-op latency is 3 cycles: IDLE (req+gnt), WAIT (rvalid), DONE.
  - The upstream instruction is held by stall and is not re-accepted in DONE.
- Alignment (addr[1:0]):
  - LH/LHU/SH require addr[0]=0; LW/SW require addr[1:0]=0.
  - Misaligned in IDLE: no bus request, misalign=1 for one cycle, m_RegWrite=0, stall=0.
- Load extract: lane byte = rdata[8*addr[1:0]+:8]; halfword = rdata[16*addr[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Other funct3 values are treated as LW.
- Store: SB be=0001<<addr[1:0], wdata=byte replicated x4. SH be=0011<<(2*addr[1]), wdata=half replicated x2. SW be=1111.
- Stores complete on mem_rvalid (ack); rdata is ignored. For loads the m_MemToReg value is the latched one.
- Reset mid-transaction: abort immediately to IDLE, mem_req=0. Late mem_rvalid in IDLE is ignored.

Optional Feature:
LSU_TIMEOUT_EN
- Defined:
  - a counter runs in REQ and WAIT; it clears on entry to REQ/WAIT from IDLE.
  - If TIMEOUT_CYCLES cycles elapse without mem_gnt (REQ) or mem_rvalid (WAIT), go to DONE with m_read_data=32'hDEADBEEF and m_RegWrite=0.
  - bus_err (extra 1-bit output) pulses for that DONE cycle.
- Undefined: no counter, no bus_err port; the unit waits indefinitely.

Test Plan:
- ALU op, x_valid=1, RegWrite=1, alu=32'h1234, rd=5 -> same cycle: stall=0, m_reg_data=32'h1234, m_rd=5, m_RegWrite=1; no mem_req.
- LB at addr 32'h103, gnt immediate, rvalid next cycle with rdata=32'h80FF_0000 -> mem_addr=32'h100, stall high for 2 cycles, DONE m_read_data=32'hFFFF_FF80.
- LHU at 32'h202, gnt delayed 3 cycles, rdata=32'h8001_7FFF -> mem_req held for 4 cycles with stable addr, m_read_data=32'h0000_8001.
- SH at 32'h006, data=32'hAAAA_BEEF -> mem_we=1, mem_be=4'b1100, mem_wdata=32'hBEEF_BEEF; on ack m_RegWrite=0.
- LW at 32'h001 -> misalign pulse, no mem_req, stall=0, m_RegWrite=0.
- rst asserted while in WAIT, then rvalid arrives after release -> mem_req=0, state IDLE, no m_RegWrite. With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no rvalid -> DONE after 4 cycles, m_read_data=32'hDEADBEEF, bus_err=1.
